// File: rtl/countdown_timer_slave_pkg.sv
// Shared bus codes for the master control bus and the countdown timer FSM encoding.
// Imported by the timer slave; the master and the other slaves use the same MC_* codes.
package countdown_timer_slave_pkg;

    localparam logic [1:0] MC_IDLE = 2'b00;
    localparam logic [1:0] MC_PLAY = 2'b01;
    localparam logic [1:0] MC_WIN  = 2'b10;
    localparam logic [1:0] MC_LOSE = 2'b11;

    localparam logic [3:0] SO_IDLE    = 4'h0;
    localparam logic [3:0] SO_RUN     = 4'h1;
    localparam logic [3:0] SO_FROZEN  = 4'h2;
    localparam logic [3:0] SO_EXPIRED = 4'hF;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_LOAD,
        TS_RUN,
        TS_FROZEN,
        TS_EXPIRED
    } timer_state_t;

    // LOAD is reported as RUN so the master never sees a transient code.
    function automatic logic [3:0] status_code(input timer_state_t s);
        case (s)
            TS_LOAD, TS_RUN: status_code = SO_RUN;
            TS_FROZEN:       status_code = SO_FROZEN;
            TS_EXPIRED:      status_code = SO_EXPIRED;
            default:         status_code = SO_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/countdown_timer_slave_bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load; saturates at 00 so it
// never underflows or holds a non-BCD digit.
module bcd_down_counter #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] digits,
    output logic       zero
);

    assign zero = (digits == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= RESET_VALUE;
        end else if (load) begin
            digits <= load_value;
        end else if (dec && !zero) begin
            if (digits[3:0] == 4'd0) begin
                digits <= {digits[7:4] - 4'd1, 4'd9};
            end else begin
                digits[3:0] <= digits[3:0] - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_slave.sv
// Round timer slave: decodes MASTER_CONTROL, counts the round limit down in
// seconds while in PLAY and reports IDLE/RUN/FROZEN/EXPIRED to the master.
//
// state   | meaning
// IDLE    | digits hold the limit, waiting for PLAY
// LOAD    | one cycle: reload digits, clear prescaler
// RUN     | prescaler running, one decrement per CLK_FREQ cycles
// FROZEN  | game won/lost, digits and prescaler hold
// EXPIRED | reached 00, holds until master returns to IDLE
module countdown_timer_slave
    import countdown_timer_slave_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int LIMIT_TENS  = 6,
    parameter int LIMIT_UNITS = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MASTER_CONTROL,
    output logic [3:0] STATE_OUT,
    output logic [7:0] SECONDS_BCD,
    output logic       TIMER_RUNNING,
    output logic       SEC_PULSE
);

    localparam int            PW       = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);
    localparam logic [7:0]    LIMIT    = {4'(LIMIT_TENS), 4'(LIMIT_UNITS)};

    timer_state_t  state, state_next;
    logic [PW-1:0] prescaler;
    logic [7:0]    digits;
    logic          zero;
    logic          tick;
    logic          play;
    logic          dec;
    logic          load;

    assign play = (MASTER_CONTROL == MC_PLAY);
    assign tick = (state == TS_RUN) && (prescaler == PRE_LAST);
    // A control change on the tick cycle wins over the decrement.
    assign dec  = tick && play;
    assign load = (state_next == TS_IDLE) || (state == TS_LOAD);

    always_comb begin
        state_next = state;
        case (state)
            TS_IDLE:    if (play) state_next = TS_LOAD;
            TS_LOAD:    state_next = play ? TS_RUN : TS_IDLE;
            TS_RUN: begin
                if (MASTER_CONTROL == MC_IDLE) begin
                    state_next = TS_IDLE;
                end else if (!play) begin
                    state_next = TS_FROZEN;
                end else if (tick && (digits == 8'h01 || zero)) begin
                    state_next = TS_EXPIRED;
                end
            end
            TS_FROZEN,
            TS_EXPIRED: if (MASTER_CONTROL == MC_IDLE) state_next = TS_IDLE;
            default:    state_next = TS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= TS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prescaler <= '0;
        end else if (load || state == TS_IDLE) begin
            prescaler <= '0;
        end else if (state == TS_RUN && play) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STATE_OUT     <= SO_IDLE;
            TIMER_RUNNING <= 1'b0;
            SEC_PULSE     <= 1'b0;
        end else begin
            STATE_OUT     <= status_code(state_next);
            TIMER_RUNNING <= (state_next == TS_LOAD) || (state_next == TS_RUN);
            SEC_PULSE     <= dec;
        end
    end

    bcd_down_counter #(
        .RESET_VALUE(LIMIT)
    ) u_counter (
        .clk        (CLK),
        .rst_n      (RESET),
        .load       (load),
        .load_value (LIMIT),
        .dec        (dec),
        .digits     (digits),
        .zero       (zero)
    );

    assign SECONDS_BCD = digits;

endmodule

// File: doc/countdown_timer_slave.md
# countdown_timer_slave

Slave-side responder on the master control bus: it decodes the 2-bit `MASTER_CONTROL` issued by the master state machine and returns a 4-bit `STATE_OUT` status word. While the game is in PLAY it counts a per-round time limit down in seconds. On expiry it reports a timeout code, which the master uses to force the LOSE transition. It also drives the remaining seconds as two BCD digits for the 7-segment/VGA display paths.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: CLK cycles per second tick; legal range ≥ 2. Benches use a small value.
- `LIMIT_TENS`, default 6: tens digit of the round time limit, 0–9.
- `LIMIT_UNITS`, default 0: units digit of the round time limit, 0–9. The combined limit must be 01–99; 00 is illegal.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RESET`  in  1  asynchronous, active-low reset.
- `MASTER_CONTROL`  in  2  master command: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE. Synchronous to `CLK`.
- `STATE_OUT`  out  4  status to master: 0 IDLE, 1 RUN (includes LOAD), 2 FROZEN, F EXPIRED.
- `SECONDS_BCD`  out  8  remaining seconds: [7:4] tens, [3:0] units.
- `TIMER_RUNNING`  out  1  high in LOAD and RUN.
- `SEC_PULSE`  out  1  one-cycle pulse on each decrement.

## Operation
FSM states: IDLE, LOAD, RUN, FROZEN, EXPIRED.
- **IDLE**: `SECONDS_BCD` holds the limit; prescaler is 0. `MASTER_CONTROL`=PLAY moves to LOAD; other codes stay in IDLE.
- **LOAD** (exactly 1 cycle): reload the digits with the limit, clear the prescaler, go to RUN. If `MASTER_CONTROL` is not PLAY in this cycle, go to IDLE instead.
- **RUN**: the prescaler counts 0..`CLK_FREQ`-1, then wraps to 0 and issues a tick.
  - A tick decrements the BCD value: units 0 borrows (units becomes 9, tens decrements); otherwise units decrements.
  - A tick taking the value 01 to 00 enters EXPIRED on the same edge.
  - `MASTER_CONTROL`=WIN or LOSE moves to FROZEN.
  - `MASTER_CONTROL`=IDLE moves to IDLE.
- **FROZEN**: digits and prescaler hold. `MASTER_CONTROL`=IDLE moves to IDLE; PLAY does not restart the timer, a restart requires passing through IDLE.
- **EXPIRED**: digits hold 00. `MASTER_CONTROL`=IDLE moves to IDLE; any other code stays in EXPIRED.
- Entry to IDLE from any state reloads the digits with the limit and clears the prescaler.
- Simultaneous tick and a non-PLAY `MASTER_CONTROL` in RUN: the control change wins. No decrement, no `SEC_PULSE`, no expiry.
- Digits never underflow below 00; they never hold non-BCD values.
- Prescaler width is `$clog2(CLK_FREQ)`. Compare against `CLK_FREQ`-1 at full width; no truncation.

## Timing
- All outputs are registered and change only on rising `CLK`, or asynchronously on `RESET` assertion.
- Reset values: state IDLE, `STATE_OUT`=0, `SECONDS_BCD`={`LIMIT_TENS`,`LIMIT_UNITS`}, `TIMER_RUNNING`=0, `SEC_PULSE`=0, prescaler 0.
- `STATE_OUT` reflects the new state one cycle after the causing input is sampled.
- PLAY sampled at edge k:
  - edge k: state LOAD.
  - edge k+1: state RUN.
  - edge k+1+`CLK_FREQ`: first decrement, with `SEC_PULSE` high for that one cycle.
- Decrements then occur every `CLK_FREQ` cycles.
- Expiry: `SECONDS_BCD`=00, `STATE_OUT`=F and `SEC_PULSE`=1 all appear on the same edge.
- Reset asserted mid-RUN: outputs take their reset values immediately. The first count after deassertion requires a fresh PLAY.

## Structure
- Shared package:
  - `MASTER_CONTROL` code constants (IDLE/PLAY/WIN/LOSE), shared with the master and the other slaves.
  - `STATE_OUT` code constants.
  - Timer FSM state typedef.
- One sub-module, `bcd_down_counter`: two-digit BCD down counter.
  - Inputs: load, load value, decrement enable.
  - Outputs: digits, zero flag.
  - Async active-low reset.
- The FSM, prescaler and control decode stay in `countdown_timer_slave`.

## Test plan
- **Reset/idle**: `CLK_FREQ`=4, limit 03; release `RESET` with `MASTER_CONTROL`=00 → `STATE_OUT`=0, `SECONDS_BCD`=03, `TIMER_RUNNING`=0, all held for 20 cycles.
- **Full countdown**: `MASTER_CONTROL`=01 → LOAD then RUN (`STATE_OUT`=1).
  - `SECONDS_BCD` shows 02, 01, 00 at 4-cycle intervals, each with a single `SEC_PULSE`.
  - `STATE_OUT`=F on the 00 edge.
  - Holding 01 keeps EXPIRED; driving 00 returns to IDLE with 03.
- **Borrow**: limit 10, `CLK_FREQ`=3 → sequence 10, 09, 08, with no non-BCD value such as 0F.
- **Freeze**: during RUN at 02, drive 10 (WIN) on the tick cycle → `STATE_OUT`=2, `SECONDS_BCD` stays 02, no pulse.
  - Driving 01 stays FROZEN; 00 then 01 restarts from 03.
- **Async reset mid-RUN**: pull `RESET` low between clock edges → outputs reach reset values before the next edge; no count after release until PLAY.
- **Limit 01**: first tick gives 00, `STATE_OUT`=F and `SEC_PULSE` on the same edge.
